aes_round_iter: RTL and testbench
=================================

# aes_round_iter

Iterative AES cipher datapath: one round per clock over a single 128-bit state register, for encryption or decryption selected per block. It generalises the single-cycle combinational encrypt round to a parametrised round count (AES-128/192/256) and adds decrypt mode, a start/ready/valid handshake, and a round-key request port. The key schedule sits outside this block and answers `Round_idx` with `Key` in the same cycle. This block sits between the key-expansion store and the block-mode controller.

## Interface
- `NR`, default 10: number of rounds. Legal values are 10, 12 and 14; any other value is a configuration error.
- `clk` input 1: the single clock.
- `rst` input 1: asynchronous, active-high reset.
- `Start` input 1: request to accept a block. Sampled only while `Ready`=1.
- `Mode` input 1: 0 selects encrypt, 1 selects decrypt. Sampled with `Start`.
- `Data_in` input 128: plaintext or ciphertext. `Data_in[127:120]` is byte 0 in FIPS-197 order, column-major.
- `Key` input 128: the round key for `Round_idx`. It must be valid combinationally in the same cycle.
- `Round_idx` output 4: index of the round key the block needs this cycle.
- `Ready` output 1: the block is idle and can accept a block.
- `Data_out` output 128: result. Held stable until the next completion.
- `Valid` output 1: one-cycle pulse marking a new `Data_out`.

## Operation
- Internal state is FSM {IDLE, RUN}, a 4-bit round counter `rnd`, a 128-bit `state` register, and a latched `mode_q`.
- IDLE:
  - `Ready`=1.
  - `Round_idx` = `Mode` ? NR : 0. This is combinational from the `Mode` input so the initial key is already presented.
  - On `Start`:
    - encrypt: `state` <= `Data_in` ^ `Key`, `rnd` <= 1.
    - decrypt: `state` <= `Data_in` ^ `Key`, `rnd` <= NR-1.
    - In both cases `mode_q` <= `Mode` and the FSM goes to RUN.
- RUN, encrypt:
  - `Round_idx` = `rnd`.
  - For `rnd` < NR: `state` <= MixColumns(ShiftRows(SubBytes(state))) ^ `Key`, then `rnd`++.
  - For `rnd` = NR (final round): `state` is not updated. `Data_out` <= ShiftRows(SubBytes(state)) ^ `Key`, `Valid` <= 1, FSM goes to IDLE.
- RUN, decrypt:
  - `Round_idx` = `rnd`.
  - For `rnd` > 0: `state` <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ `Key`), then `rnd`--.
  - For `rnd` = 0 (final round): `Data_out` <= InvSubBytes(InvShiftRows(state)) ^ `Key`, `Valid` <= 1, FSM goes to IDLE.
- Datapath resources:
  - Forward and inverse transforms are separate combinational functions; only the `mode_q`-selected result is written.
  - The existing SubBytes, ShiftRows, MixColumns and AddRoundKey blocks are reused for the forward path. Inverse counterparts are added in the same style.
- Boundary behaviour:
  - `Start` while `Ready`=0 is ignored; no queueing.
  - `Mode` and `Data_in` changes during RUN have no effect.
  - `Valid` is high for exactly one cycle per accepted block.
  - `Data_out` changes only on the edge that sets `Valid`.
  - `rnd` never wraps. The decrypt final-round compare is `rnd`==0, checked before any decrement.

## Timing
- Reset values, applied immediately and asynchronously:
  - FSM = IDLE, `rnd` = 0, `state` = 0, `mode_q` = 0.
  - `Data_out` = 0, `Valid` = 0, `Ready` = 1.
- Reset asserted mid-block aborts the block: no `Valid`, and `Data_out` is cleared to 0.
- Latency, with the `Start` accept edge as E0:
  - Rounds are applied on edges E1..E(NR).
  - `Valid`=1 and the result is on `Data_out` in the cycle after E(NR). Total latency is NR+1 edges.
- `Ready` deasserts after E0 and reasserts after E(NR), i.e. in the same cycle as `Valid`.
  - A `Start` in that cycle is accepted, giving back-to-back throughput of one block per NR+1 cycles.
  - `Round_idx` in that cycle reflects the new `Mode` input.
- `Round_idx` is combinational:
  - from `Mode` in IDLE;
  - registered-derived from `rnd` in RUN.
  - `Key` has a full-cycle combinational path to the `state` and `Data_out` registers.

## Test plan
- Encrypt, NR=10, FIPS-197 C.1 (key 000102…0f, round keys from the bench model). `Data_in`=00112233445566778899aabbccddeeff -> `Valid` 11 cycles after accept, `Data_out`=69c4e0d86a7b0430d8cdb78070b4c55a. `Round_idx` sequence 0,1,…,10.
- Decrypt, NR=10, same key. `Data_in`=69c4e0d86a7b0430d8cdb78070b4c55a -> `Data_out`=00112233445566778899aabbccddeeff. `Round_idx` sequence 10,9,…,0.
- Encrypt, NR=14, FIPS-197 C.3 (key 000102…1f), same plaintext -> `Data_out`=8ea2b7ca516745bfeafc49904b496089 after 15 cycles. Also run NR=12 against C.2 -> dda97ca4864cdfe06eaf70a0ec0d7191.
- Back-to-back: encrypt with `Start` held high continuously, then alternate encrypt/decrypt with `Mode` toggled at each accept -> `Valid` pulses exactly every NR+1 cycles with correct results. `Start` pulses while `Ready`=0 are ignored.
- `rst` pulsed at round 5 of an encrypt -> `Valid` never fires for that block, `Data_out`=0 and `Ready`=1 immediately. A following C.1 encrypt is correct.
- Stability: after a `Valid`, toggle `Data_in`, `Mode` and `Key` randomly with `Start`=0 for 20 cycles -> `Data_out` unchanged, `Valid`=0.

Source files
------------

// File: rtl/aes_round_iter.sv
// Iterative AES encrypt/decrypt: one round per clock, NR+1 edges from accept to Valid.
// No backpressure: Start is accepted only while Ready; Valid is a single-cycle pulse.
module aes_round_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Start,
    input  logic         Mode,
    input  logic [127:0] Data_in,
    input  logic [127:0] Key,
    output logic [3:0]   Round_idx,
    output logic         Ready,
    output logic [127:0] Data_out,
    output logic         Valid
);

    generate
        if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
            $error("aes_round_iter: NR must be 10, 12 or 14");
        end
    endgenerate

    localparam logic [3:0] NR4 = 4'(NR);

    typedef enum logic {IDLE, RUN} fsm_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the field inverse (and maps 0 to 0, as the S-box needs)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Byte (row r, column c) lives at index 4c+r, column-major
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    // Circulant column multiply; m holds the first matrix row, MSB byte first
    function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic [31:0] m);
        logic [127:0] o;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gf_mul(s[127-8*(4*c+k) -: 8], m[31-8*((k-r+4)%4) -: 8]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return mix_cols(s, 32'h02030101);
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return mix_cols(s, 32'h0e0b0d09);
    endfunction

    fsm_t         r_fsm, w_fsm_nxt;
    logic [3:0]   r_rnd, w_rnd_nxt;
    logic [127:0] r_state, w_state_nxt;
    logic         r_mode, w_mode_nxt;
    logic [127:0] r_data_out, w_data_out_nxt;
    logic         r_valid, w_valid_nxt;

    logic [127:0] w_enc_sr, w_enc_mid, w_enc_last;
    logic [127:0] w_dec_last, w_dec_mid;

    assign w_enc_sr   = shift_rows(sub_bytes(r_state));
    assign w_enc_mid  = mix_columns(w_enc_sr) ^ Key;
    assign w_enc_last = w_enc_sr ^ Key;
    assign w_dec_last = inv_sub_bytes(inv_shift_rows(r_state)) ^ Key;
    assign w_dec_mid  = inv_mix_columns(w_dec_last);

    always_comb begin
        w_fsm_nxt      = r_fsm;
        w_rnd_nxt      = r_rnd;
        w_state_nxt    = r_state;
        w_mode_nxt     = r_mode;
        w_data_out_nxt = r_data_out;
        w_valid_nxt    = 1'b0;
        Round_idx      = r_rnd;
        case (r_fsm)
            IDLE: begin
                // Present the initial key from the live Mode so it is ready on the accept edge
                Round_idx = Mode ? NR4 : 4'd0;
                if (Start) begin
                    w_state_nxt = Data_in ^ Key;
                    w_rnd_nxt   = Mode ? (NR4 - 4'd1) : 4'd1;
                    w_mode_nxt  = Mode;
                    w_fsm_nxt   = RUN;
                end
            end
            RUN: begin
                if (!r_mode) begin
                    if (r_rnd == NR4) begin
                        w_data_out_nxt = w_enc_last;
                        w_valid_nxt    = 1'b1;
                        w_fsm_nxt      = IDLE;
                    end else begin
                        w_state_nxt = w_enc_mid;
                        w_rnd_nxt   = r_rnd + 4'd1;
                    end
                end else begin
                    if (r_rnd == 4'd0) begin
                        w_data_out_nxt = w_dec_last;
                        w_valid_nxt    = 1'b1;
                        w_fsm_nxt      = IDLE;
                    end else begin
                        w_state_nxt = w_dec_mid;
                        w_rnd_nxt   = r_rnd - 4'd1;
                    end
                end
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm      <= IDLE;
            r_rnd      <= 4'd0;
            r_state    <= 128'd0;
            r_mode     <= 1'b0;
            r_data_out <= 128'd0;
            r_valid    <= 1'b0;
        end else begin
            r_fsm      <= w_fsm_nxt;
            r_rnd      <= w_rnd_nxt;
            r_state    <= w_state_nxt;
            r_mode     <= w_mode_nxt;
            r_data_out <= w_data_out_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    assign Ready    = (r_fsm == IDLE);
    assign Data_out = r_data_out;
    assign Valid    = r_valid;

endmodule

// File: tb/tb_aes_round_iter.sv
// Directed FIPS-197 vectors on NR=10/12/14 instances, with a bench-side key schedule.
module tb_aes_round_iter;

    logic         clk;
    logic         rst;
    logic         st   [3];
    logic         md   [3];
    logic [127:0] din  [3];
    logic [127:0] key  [3];
    logic [3:0]   ri   [3];
    logic         rdy  [3];
    logic [127:0] dout [3];
    logic         vld  [3];

    logic [127:0] rks [3][15];
    logic         key_rand_en;
    logic [127:0] key_rnd;
    logic [2047:0] sbv;
    int           n_checks;
    int           n_fail;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_round_iter #(.NR(10)) u_nr10 (
        .clk(clk), .rst(rst), .Start(st[0]), .Mode(md[0]), .Data_in(din[0]), .Key(key[0]),
        .Round_idx(ri[0]), .Ready(rdy[0]), .Data_out(dout[0]), .Valid(vld[0]));
    aes_round_iter #(.NR(12)) u_nr12 (
        .clk(clk), .rst(rst), .Start(st[1]), .Mode(md[1]), .Data_in(din[1]), .Key(key[1]),
        .Round_idx(ri[1]), .Ready(rdy[1]), .Data_out(dout[1]), .Valid(vld[1]));
    aes_round_iter #(.NR(14)) u_nr14 (
        .clk(clk), .rst(rst), .Start(st[2]), .Mode(md[2]), .Data_in(din[2]), .Key(key[2]),
        .Round_idx(ri[2]), .Ready(rdy[2]), .Data_out(dout[2]), .Valid(vld[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External key store answering Round_idx in the same cycle
    always_comb begin
        key[0] = key_rand_en ? key_rnd : rks[0][ri[0]];
        key[1] = rks[1][ri[1]];
        key[2] = rks[2][ri[2]];
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] x);
        return sbv[2047-8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
    endfunction

    // Key bytes are 00,01,02,... as in the FIPS-197 appendix C examples
    task automatic expand(input int d, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++)
            w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++)
            rks[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Entered and left at a negedge; returns in the Valid cycle
    task automatic run_block(input int d, input logic m, input logic [127:0] din_v,
                             input logic [127:0] exp, input string tag, input int nr,
                             input bit hold);
        int           bad_idx;
        int           bad_run;
        logic [127:0] dprev;
        bad_idx = 0;
        bad_run = 0;
        dprev   = dout[d];
        st[d]   = 1'b1;
        md[d]   = m;
        din[d]  = din_v;
        #1;
        check({tag, "_ready"}, 128'(rdy[d]), 128'd1);
        check({tag, "_idx0"}, 128'(ri[d]), m ? 128'(nr) : 128'd0);
        for (int j = 0; j < nr; j++) begin
            @(negedge clk);
            if (ri[d] !== (m ? 4'(nr-1-j) : 4'(j+1))) bad_idx++;
            if (vld[d] !== 1'b0 || rdy[d] !== 1'b0 || dout[d] !== dprev) bad_run++;
            din[d] = {$urandom, $urandom, $urandom, $urandom};
            md[d]  = 1'($urandom_range(0, 1));
            if (!hold) st[d] = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check({tag, "_idx_seq"}, 128'(bad_idx), 128'd0);
        check({tag, "_busy"}, 128'(bad_run), 128'd0);
        check({tag, "_valid"}, 128'(vld[d]), 128'd1);
        check({tag, "_ready_end"}, 128'(rdy[d]), 128'd1);
        check({tag, "_data"}, dout[d], exp);
        if (!hold) st[d] = 1'b0;
    endtask

    initial begin
        int bad;
        n_checks    = 0;
        n_fail      = 0;
        key_rand_en = 1'b0;
        key_rnd     = '0;
        for (int i = 0; i < 3; i++) begin
            st[i]  = 1'b0;
            md[i]  = 1'b0;
            din[i] = '0;
        end
        sbv = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
               128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
               128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
               128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
               128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
               128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
               128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
               128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        expand(0, 4);
        expand(1, 6);
        expand(2, 8);
        rst = 1'b1;
        #1;
        check("rst_data_out", dout[0], 128'd0);
        check("rst_valid", 128'(vld[0]), 128'd0);
        check("rst_ready", 128'(rdy[0]), 128'd1);
        check("rst_round_idx", 128'(ri[0]), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        run_block(0, 1'b0, PT, CT128, "enc128", 10, 1'b0);
        @(negedge clk);
        check("enc128_valid_once", 128'(vld[0]), 128'd0);
        run_block(0, 1'b1, CT128, PT, "dec128", 10, 1'b0);
        run_block(2, 1'b0, PT, CT256, "enc256", 14, 1'b0);
        run_block(1, 1'b0, PT, CT192, "enc192", 12, 1'b0);
        run_block(1, 1'b1, CT192, PT, "dec192", 12, 1'b0);
        @(negedge clk);

        // Start held high: each block is accepted in the previous block's Valid cycle
        run_block(0, 1'b0, PT, CT128, "b2b_enc_a", 10, 1'b1);
        run_block(0, 1'b0, PT, CT128, "b2b_enc_b", 10, 1'b1);
        run_block(0, 1'b1, CT128, PT, "alt_dec_a", 10, 1'b1);
        run_block(0, 1'b0, PT, CT128, "alt_enc", 10, 1'b1);
        run_block(0, 1'b1, CT128, PT, "alt_dec_b", 10, 1'b0);

        bad = 0;
        key_rand_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (vld[0] !== 1'b0 || dout[0] !== PT) bad++;
            din[0]  = {$urandom, $urandom, $urandom, $urandom};
            md[0]   = 1'($urandom_range(0, 1));
            key_rnd = {$urandom, $urandom, $urandom, $urandom};
        end
        check("hold_stable", 128'(bad), 128'd0);
        key_rand_en = 1'b0;
        md[0] = 1'b0;

        @(negedge clk);
        st[0]  = 1'b1;
        din[0] = PT;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_data_out", dout[0], 128'd0);
        check("abort_ready", 128'(rdy[0]), 128'd1);
        check("abort_valid", 128'(vld[0]), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (vld[0] !== 1'b0) bad++;
        end
        check("abort_no_valid", 128'(bad), 128'd0);
        run_block(0, 1'b0, PT, CT128, "post_abort", 10, 1'b0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
